// File: rtl/system_parameters_pkg.sv
// Shared constants for the double-buffered acquisition parameter bank:
// CTRL/STATUS bit positions and the register-map offsets derived from NUM_CH.
package system_parameters_pkg;

  localparam int CTRL_COMMIT_BIT    = 0;
  localparam int CTRL_AUTO_BIT      = 1;

  localparam int STATUS_PENDING_BIT = 0;
  localparam int STATUS_BUSY_BIT    = 1;
  localparam int STATUS_COUNT_LSB   = 16;
  localparam int STATUS_COUNT_W     = 16;

  // CTRL sits directly after the shadow and active windows
  function automatic int ctrl_offset(input int num_ch);
    return 2 * num_ch;
  endfunction

  // STATUS follows CTRL
  function automatic int status_offset(input int num_ch);
    return (2 * num_ch) + 1;
  endfunction

endpackage

// File: rtl/system_parameters_chan.sv
// One parameter channel: a CPU-writable shadow register with byte lanes and
// an active register that copies the shadow only when commit is asserted.
module system_parameters_chan #(
  parameter int               DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   writedata,
  input  logic                commit,
  output logic [DATA_W-1:0]   shadow,
  output logic [DATA_W-1:0]   active
);

  logic [DATA_W-1:0] shadow_r;
  logic [DATA_W-1:0] active_r;

  // Shadow register: byte-lane merge of CPU writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_r <= RESET_VAL;
    end else if (wr_en) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        shadow_r[8*b +: 8] <= byteenable[b] ? writedata[8*b +: 8] : shadow_r[8*b +: 8];
      end
    end else begin
      shadow_r <= shadow_r;
    end
  end

  // Active register: takes the pre-write shadow value on commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_r <= RESET_VAL;
    end else if (commit) begin
      active_r <= shadow_r;
    end else begin
      active_r <= active_r;
    end
  end

  assign shadow = shadow_r;
  assign active = active_r;

endmodule

// File: rtl/system_parameters_bank.sv
// Bank of NUM_CH double-buffered Avalon-MM parameter registers for the NMR
// sequencer. Shadow values reach the active outputs only through a commit
// that waits for the sequencer to be idle, so a scan never sees a partial set.
module system_parameters_bank
  import system_parameters_pkg::*;
#(
  parameter int                    NUM_CH    = 4,
  parameter int                    DATA_W    = 32,
  parameter int                    ADDR_W    = 4,
  parameter logic [NUM_CH*32-1:0]  RESET_VAL = {NUM_CH{32'd255}}
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic                     read_n,
  input  logic [DATA_W/8-1:0]      byteenable,
  input  logic [DATA_W-1:0]        writedata,
  output logic [DATA_W-1:0]        readdata,
  output logic                     readdatavalid,
  input  logic                     seq_busy,
  output logic [NUM_CH*DATA_W-1:0] out_port,
  output logic                     param_updated,
  output logic                     commit_pending
);

  localparam logic [ADDR_W-1:0] SHADOW_END_C  = ADDR_W'(NUM_CH);
  localparam logic [ADDR_W-1:0] ACTIVE_END_C  = ADDR_W'(2 * NUM_CH);
  localparam logic [ADDR_W-1:0] CTRL_ADDR_C   = ADDR_W'(ctrl_offset(NUM_CH));
  localparam logic [ADDR_W-1:0] STATUS_ADDR_C = ADDR_W'(status_offset(NUM_CH));

  logic                      wr_s;
  logic                      rd_s;
  logic                      is_shadow_s;
  logic                      ctrl_wr_s;
  logic                      set_pending_s;
  logic                      commit_s;
  logic [NUM_CH-1:0]         chan_wr_s;
  logic [DATA_W-1:0]         shadow_s [NUM_CH];
  logic [DATA_W-1:0]         active_s [NUM_CH];
  logic [DATA_W-1:0]         shadow_sel_s;
  logic [DATA_W-1:0]         active_sel_s;
  logic [31:0]               ctrl_word_s;
  logic [31:0]               status_word_s;
  logic [DATA_W-1:0]         rd_mux_s;

  logic                      pending_r;
  logic                      auto_r;
  logic [STATUS_COUNT_W-1:0] commit_count_r;
  logic                      param_updated_r;
  logic [DATA_W-1:0]         readdata_r;
  logic                      readdatavalid_r;

  assign wr_s        = chipselect & ~write_n;
  assign rd_s        = chipselect & ~read_n;
  assign is_shadow_s = (address < SHADOW_END_C);
  assign ctrl_wr_s   = wr_s & (address == CTRL_ADDR_C) & byteenable[0];

  // A COMMIT write, or any shadow write while AUTO is on, requests a commit
  assign set_pending_s = (ctrl_wr_s & writedata[CTRL_COMMIT_BIT]) |
                         (auto_r & wr_s & is_shadow_s);
  assign commit_s      = pending_r & ~seq_busy;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    assign chan_wr_s[g] = wr_s & (address == ADDR_W'(g));

    system_parameters_chan #(
      .DATA_W    (DATA_W),
      .RESET_VAL (RESET_VAL[32*g +: DATA_W])
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (chan_wr_s[g]),
      .byteenable (byteenable),
      .writedata  (writedata),
      .commit     (commit_s),
      .shadow     (shadow_s[g]),
      .active     (active_s[g])
    );

    assign out_port[DATA_W*g +: DATA_W] = active_s[g];
  end

  // Pending flag: a commit clears it, but a same-cycle request re-arms it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_r <= 1'b0;
    end else if (commit_s) begin
      pending_r <= set_pending_s;
    end else if (set_pending_s) begin
      pending_r <= 1'b1;
    end else begin
      pending_r <= pending_r;
    end
  end

  // AUTO mode bit, writable through CTRL byte lane 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      auto_r <= 1'b0;
    end else if (ctrl_wr_s) begin
      auto_r <= writedata[CTRL_AUTO_BIT];
    end else begin
      auto_r <= auto_r;
    end
  end

  // Commit counter (wraps) and the update pulse aligned with the active change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      commit_count_r  <= 16'd0;
      param_updated_r <= 1'b0;
    end else if (commit_s) begin
      commit_count_r  <= commit_count_r + 16'd1;
      param_updated_r <= 1'b1;
    end else begin
      commit_count_r  <= commit_count_r;
      param_updated_r <= 1'b0;
    end
  end

  // Read-path selection: per-window one-hot OR, then the register map
  always_comb begin
    shadow_sel_s  = '0;
    active_sel_s  = '0;
    ctrl_word_s   = 32'd0;
    status_word_s = 32'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      shadow_sel_s = shadow_sel_s | ((address == ADDR_W'(i)) ? shadow_s[i] : '0);
      active_sel_s = active_sel_s | ((address == ADDR_W'(NUM_CH + i)) ? active_s[i] : '0);
    end
    ctrl_word_s[CTRL_AUTO_BIT]                                    = auto_r;
    status_word_s[STATUS_PENDING_BIT]                             = pending_r;
    status_word_s[STATUS_BUSY_BIT]                                = seq_busy;
    status_word_s[STATUS_COUNT_LSB +: STATUS_COUNT_W]             = commit_count_r;
    if (is_shadow_s) begin
      rd_mux_s = shadow_sel_s;
    end else if (address < ACTIVE_END_C) begin
      rd_mux_s = active_sel_s;
    end else if (address == CTRL_ADDR_C) begin
      rd_mux_s = ctrl_word_s[DATA_W-1:0];
    end else if (address == STATUS_ADDR_C) begin
      rd_mux_s = status_word_s[DATA_W-1:0];
    end else begin
      rd_mux_s = '0;
    end
  end

  // Registered read response, one cycle after the read strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_r      <= '0;
      readdatavalid_r <= 1'b0;
    end else if (rd_s) begin
      readdata_r      <= rd_mux_s;
      readdatavalid_r <= 1'b1;
    end else begin
      readdata_r      <= readdata_r;
      readdatavalid_r <= 1'b0;
    end
  end

  assign readdata       = readdata_r;
  assign readdatavalid  = readdatavalid_r;
  assign param_updated  = param_updated_r;
  assign commit_pending = pending_r;

endmodule
